uart_rx_deframer: RTL and testbench

Receive-side UART deframer for the Princess UART path. It samples the asynchronous serial input with 16x oversampling, validates start, data, parity and stop bits, and presents each received byte with its error flags on a valid/ready interface. It sits directly upstream of the UART receive buffer and register interface, and is the stage the UART test program drives through the serial pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx_deframer.sv | 140 ++++++++++++++
 tb/tb_uart_rx_deframer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;
  localparam int unsigned DATA_BITS  = 8;

  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  // True when data plus received parity bit do not give the requested parity.
  function automatic logic parity_error(input logic [7:0] data, input logic pbit,
                                        input logic odd);
    return ((^data) ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter from div to 0, reloaded on tick or on request.
module uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] div,
  input  logic         reload,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload || tick) begin
      cnt <= div;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises RxD, oversamples 16x, checks parity/stop
// and hands each byte with its error flags to a valid/ready consumer.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLK_DIV_W   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [CLK_DIV_W-1:0] BaudDiv,
  input  logic                 ParityEn,
  input  logic                 ParityOdd,
  input  logic                 RxD,
  output logic [7:0]           RxData,
  output logic                 RxValid,
  input  logic                 RxReady,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 Overrun
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rxs;
  rx_state_e              state;
  logic [3:0]             samp;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic                   par_err;
  logic                   tick;
  logic                   reload;

  // Sync flops reset high so a line held low after reset looks like a fresh start edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], RxD};
    end
  end

  assign rxs    = sync_r[SYNC_STAGES-1];
  assign reload = (state == IDLE) && !rxs;

  uart_baud_tick #(.W(CLK_DIV_W)) u_tick (
    .clk    (Clk),
    .rst    (Rst),
    .div    (BaudDiv),
    .reload (reload),
    .tick   (tick)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      samp      <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      par_err   <= 1'b0;
      RxData    <= 8'h00;
      RxValid   <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      Overrun <= 1'b0;
      if (RxValid && RxReady) begin
        RxValid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            samp  <= 4'd0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (samp == MID_LAST) begin
              samp    <= 4'd0;
              bit_idx <= 3'd0;
              par_err <= 1'b0;
              state   <= rxs ? IDLE : DATA;
            end else begin
              samp <= samp + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            samp <= samp + 4'd1;
            if (samp == SAMP_LAST) begin
              shift <= {rxs, shift[7:1]};
              if (bit_idx == BIT_LAST) begin
                state <= ParityEn ? PARITY : STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
        end
        PARITY: begin
          if (tick) begin
            samp <= samp + 4'd1;
            if (samp == SAMP_LAST) begin
              par_err <= parity_error(shift, rxs, ParityOdd);
              state   <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            samp <= samp + 4'd1;
            if (samp == SAMP_LAST) begin
              // A held byte that is not being taken this cycle wins; the new one is dropped.
              if (!RxValid || RxReady) begin
                RxData    <= shift;
                ParityErr <= ParityEn & par_err;
                FrameErr  <= !rxs;
                RxValid   <= 1'b1;
              end else begin
                Overrun <= 1'b1;
              end
              state <= rxs ? IDLE : WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: a frame table plus hand sequences for
// break, glitch, overrun and mid-frame reset.
module tb_uart_rx_deframer;

  logic        Clk;
  logic        Rst;
  logic [15:0] BaudDiv;
  logic        ParityEn;
  logic        ParityOdd;
  logic        RxD;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        ParityErr;
  logic        FrameErr;
  logic        Overrun;

  uart_rx_deframer #(.CLK_DIV_W(16), .SYNC_STAGES(2)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .BaudDiv   (BaudDiv),
    .ParityEn  (ParityEn),
    .ParityOdd (ParityOdd),
    .RxD       (RxD),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxReady   (RxReady),
    .ParityErr (ParityErr),
    .FrameErr  (FrameErr),
    .Overrun   (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] div;
    logic        pen;
    logic        podd;
    logic [7:0]  data;
    logic        pbit;
    logic [7:0]  exp_data;
    logic        exp_perr;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_bad = 0;

  int   acc_cnt = 0;
  int   ovr_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic last_perr = 1'b0;
  logic last_ferr = 1'b0;
  logic prev_v = 1'b0;
  longint rise_t = 0;
  longint start_t = 0;

  // Record accepted bytes, overrun pulses and the latest RxValid rise.
  always @(negedge Clk) begin
    if (RxValid && RxReady) begin
      acc_cnt   <= acc_cnt + 1;
      last_data <= RxData;
      last_perr <= ParityErr;
      last_ferr <= FrameErr;
    end
    if (Overrun) ovr_cnt <= ovr_cnt + 1;
    if (RxValid && !prev_v) rise_t <= $time;
    prev_v <= RxValid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Drives one frame; leaves RxD at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop);
    int bclk;
    bclk = 16 * (int'(BaudDiv) + 1);
    RxD = 1'b0;
    start_t = $time;
    tick_n(bclk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      tick_n(bclk);
    end
    if (pen) begin
      RxD = pbit;
      tick_n(bclk);
    end
    RxD = stop;
    tick_n(bclk);
  endtask

  initial begin
    int a0;
    int o0;
    longint lat;

    vecs[0] = '{16'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{16'd0, 1'b1, 1'b0, 8'h07, 1'b1, 8'h07, 1'b0};
    vecs[2] = '{16'd0, 1'b1, 1'b0, 8'h07, 1'b0, 8'h07, 1'b1};
    vecs[3] = '{16'd0, 1'b1, 1'b1, 8'h07, 1'b1, 8'h07, 1'b1};
    vecs[4] = '{16'd0, 1'b1, 1'b1, 8'h07, 1'b0, 8'h07, 1'b0};
    vecs[5] = '{16'd3, 1'b0, 1'b0, 8'h81, 1'b0, 8'h81, 1'b0};
    vecs[6] = '{16'd2, 1'b1, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{16'd1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};

    Rst = 1'b1; RxD = 1'b1; BaudDiv = 16'd0; ParityEn = 1'b0; ParityOdd = 1'b0;
    RxReady = 1'b1;
    tick_n(3);
    chk("reset_valid", 32'(RxValid), 32'd0);
    chk("reset_data", 32'(RxData), 32'h00);
    chk("reset_perr", 32'(ParityErr), 32'd0);
    chk("reset_ferr", 32'(FrameErr), 32'd0);
    chk("reset_ovr", 32'(Overrun), 32'd0);
    Rst = 1'b0;
    tick_n(2);

    for (int v = 0; v < 8; v++) begin
      BaudDiv = vecs[v].div; ParityEn = vecs[v].pen; ParityOdd = vecs[v].podd;
      RxD = 1'b1;
      tick_n(32);
      a0 = acc_cnt;
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, 1'b1);
      tick_n(16 * (int'(vecs[v].div) + 1));
      chk($sformatf("v%0d_count", v), 32'(acc_cnt - a0), 32'd1);
      chk($sformatf("v%0d_data", v), 32'(last_data), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d_perr", v), 32'(last_perr), 32'(vecs[v].exp_perr));
      chk($sformatf("v%0d_ferr", v), 32'(last_ferr), 32'd0);
      chk($sformatf("v%0d_valid_drop", v), 32'(RxValid), 32'd0);
      if (v == 0) begin
        lat = (rise_t - start_t - 14) / 10;
        chk("latency_in_window", 32'(lat >= 154 && lat <= 156), 32'd1);
      end
    end

    // Framing error followed by a long break.
    BaudDiv = 16'd0; ParityEn = 1'b0; RxReady = 1'b1;
    a0 = acc_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tick_n(40 * 16);
    chk("brk_count", 32'(acc_cnt - a0), 32'd1);
    chk("brk_data", 32'(last_data), 32'h3C);
    chk("brk_ferr", 32'(last_ferr), 32'd1);
    RxD = 1'b1;
    tick_n(48);
    chk("brk_no_extra", 32'(acc_cnt - a0), 32'd1);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1);
    tick_n(16);
    chk("brk_next_count", 32'(acc_cnt - a0), 32'd2);
    chk("brk_next_data", 32'(last_data), 32'h96);
    chk("brk_next_ferr", 32'(last_ferr), 32'd0);

    // Short low glitch is rejected at the mid-start sample.
    BaudDiv = 16'd3;
    tick_n(16);
    a0 = acc_cnt;
    RxD = 1'b0;
    tick_n(20);
    RxD = 1'b1;
    tick_n(128);
    chk("glitch_none", 32'(acc_cnt - a0), 32'd0);
    chk("glitch_valid", 32'(RxValid), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    tick_n(64);
    chk("glitch_next_count", 32'(acc_cnt - a0), 32'd1);
    chk("glitch_next_data", 32'(last_data), 32'h81);

    // Back-to-back bytes with the consumer stalled.
    BaudDiv = 16'd0; RxReady = 1'b0;
    tick_n(32);
    a0 = acc_cnt; o0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    RxD = 1'b1;
    tick_n(16);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_valid_held", 32'(RxValid), 32'd1);
    chk("ovr_data_kept", 32'(RxData), 32'h11);
    chk("ovr_no_accept", 32'(acc_cnt - a0), 32'd0);
    RxReady = 1'b1;
    tick_n(1);
    chk("ovr_valid_drop", 32'(RxValid), 32'd0);
    chk("ovr_accept", 32'(acc_cnt - a0), 32'd1);
    chk("ovr_accept_data", 32'(last_data), 32'h11);

    // Reset pulse in data bit 4 of 0xF0.
    tick_n(32);
    a0 = acc_cnt;
    RxD = 1'b0;
    tick_n(16);
    for (int i = 0; i < 4; i++) begin
      RxD = 1'b0;
      tick_n(16);
    end
    RxD = 1'b1;
    tick_n(8);
    Rst = 1'b1;
    tick_n(1);
    Rst = 1'b0;
    chk("rst_mid_valid", 32'(RxValid), 32'd0);
    chk("rst_mid_data", 32'(RxData), 32'h00);
    chk("rst_mid_perr", 32'(ParityErr), 32'd0);
    chk("rst_mid_ferr", 32'(FrameErr), 32'd0);
    tick_n(8 + 16 * 4 + 32);
    chk("rst_mid_none", 32'(acc_cnt - a0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    tick_n(16);
    chk("rst_next_count", 32'(acc_cnt - a0), 32'd1);
    chk("rst_next_data", 32'(last_data), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
